// File: rtl/fp_add_pipe.sv
// fp_add_pipe: two-stage pipelined floating-point adder/subtractor with a
// valid/ready stream interface and a pass-through sideband tag.
// Stage 1 aligns the operands and adds them; stage 2 normalises the sum.
// Optional build macro FP_ADD_PIPE_SAT_EN: saturates an out-of-range exponent
// in stage 2 instead of letting it wrap.
module fp_add_pipe #(
    parameter int ExpWidth  = 8,
    parameter int MantWidth = 7,
    parameter int TagWidth  = 4
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        in_valid_i,
    output logic                        in_ready_o,
    input  logic [ExpWidth+MantWidth:0] op_a_i,
    input  logic [ExpWidth+MantWidth:0] op_b_i,
    input  logic                        sub_i,
    input  logic [TagWidth-1:0]         tag_i,
    output logic                        out_valid_o,
    input  logic                        out_ready_i,
    output logic [ExpWidth+MantWidth:0] result_o,
    output logic [TagWidth-1:0]         tag_o
);

    localparam int DataWidth    = 1 + ExpWidth + MantWidth;
    // {sign, overflow, implicit one, mantissa, guard}
    localparam int SumWidth     = MantWidth + 4;
    // Two spare bits so overflow and underflow stay distinguishable.
    localparam int ExpCalcWidth = ExpWidth + 2;

    typedef struct packed {
        logic                 sgn;
        logic [ExpWidth-1:0]  expo;
        logic [MantWidth-1:0] mant;
    } fp_t;

    // Stage registers
    logic                 s1_valid;
    logic [SumWidth-1:0]  s1_sum;
    logic [ExpWidth-1:0]  s1_exp;
    logic                 s1_sticky;
    logic [TagWidth-1:0]  s1_tag;

    logic                 s2_valid;
    logic [DataWidth-1:0] s2_result;
    logic [TagWidth-1:0]  s2_tag;

    // Stage enables: a stage may load when it is empty or its contents move on.
    logic s1_en;
    logic s2_en;

    assign s2_en       = !s2_valid || out_ready_i;
    assign s1_en       = !s1_valid || s2_en;
    assign in_ready_o  = s1_en;
    assign out_valid_o = s2_valid;
    assign result_o    = s2_result;
    assign tag_o       = s2_tag;

    // Stage 1 datapath: pick the larger-exponent operand, align the other, add.
    fp_t                       op_a;
    fp_t                       op_b;
    fp_t                       op_x;
    fp_t                       op_y;
    int                        shift_amt;
    logic [SumWidth-1:0]       x_full;
    logic [SumWidth-1:0]       y_full;
    logic signed [SumWidth-1:0] x_sig;
    logic signed [SumWidth-1:0] y_sig;
    logic signed [SumWidth-1:0] y_shifted;
    logic signed [SumWidth-1:0] sum_d;
    logic                       sticky_d;

    // Align-and-add combinational logic.
    always_comb begin
        // NOTE: every signal driven here gets a value on every path, so no latch is inferred.
        op_a      = fp_t'(op_a_i);
        op_b      = fp_t'(op_b_i);
        op_b.sgn  = op_b.sgn ^ sub_i;
        op_x      = op_a;
        op_y      = op_b;
        y_shifted = '0;
        sticky_d  = 1'b0;
        if (op_b.expo > op_a.expo) begin
            op_x = op_b;
            op_y = op_a;
        end
        shift_amt = int'(op_x.expo - op_y.expo);
        x_full    = {2'b00, 1'b1, op_x.mant, 1'b0};
        y_full    = {2'b00, 1'b1, op_y.mant, 1'b0};
        x_sig     = op_x.sgn ? -x_full : x_full;
        y_sig     = op_y.sgn ? -y_full : y_full;
        if (shift_amt <= MantWidth) begin
            y_shifted = y_sig >>> shift_amt;
            // Bits of Y that fall off below the guard bit.
            sticky_d  = |(y_sig & ~({SumWidth{1'b1}} << shift_amt));
        end
        sum_d = x_sig + y_shifted;
    end

    // Stage 1 register: holds the signed sum, larger exponent, sticky and tag.
    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (rst_i) begin
            s1_valid  <= 1'b0;
            s1_sum    <= '0;
            s1_exp    <= '0;
            s1_sticky <= 1'b0;
            s1_tag    <= '0;
        end else if (s1_en) begin
            s1_valid <= in_valid_i;
            if (in_valid_i) begin
                s1_sum    <= sum_d;
                s1_exp    <= op_x.expo;
                s1_sticky <= sticky_d;
                s1_tag    <= tag_i;
            end
        end
    end

    // Stage 2 datapath: magnitude, leading-one detect, normalise.
    logic                    neg;
    logic [SumWidth-1:0]     mag;
    logic [SumWidth-1:0]     norm;
    int                      lead;
    logic [ExpCalcWidth-1:0] exp_calc;
    logic [DataWidth-1:0]    result_d;

    // Normalisation combinational logic.
    always_comb begin
        neg = s1_sum[SumWidth-1];
        mag = s1_sum;
        if (neg) begin
            // A set sticky means the true magnitude is slightly smaller than
            // -sum, so truncation toward zero is one below it: ~sum.
            mag = s1_sticky ? ~s1_sum : -s1_sum;
        end
        lead = 0;
        for (int i = 0; i < SumWidth; i++) begin
            if (mag[i]) begin
                lead = i;
            end
        end
        // Place the leading one at bit MantWidth+2; mantissa sits just below it.
        norm     = mag << (MantWidth + 2 - lead);
        exp_calc = ExpCalcWidth'(s1_exp) + ExpCalcWidth'(lead)
                 - ExpCalcWidth'(MantWidth + 1);
        result_d = {neg, ExpWidth'(exp_calc), MantWidth'(norm >> 2)};
`ifdef FP_ADD_PIPE_SAT_EN
        if (exp_calc[ExpCalcWidth-1]) begin
            result_d = '0;
        end else if (exp_calc[ExpWidth]) begin
            result_d = {neg, {ExpWidth{1'b1}}, {MantWidth{1'b1}}};
        end
`else
`endif
        if (mag == '0) begin
            result_d = '0;
        end
    end

    // Stage 2 register: output result and tag, held while downstream stalls.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s2_valid  <= 1'b0;
            s2_result <= '0;
            s2_tag    <= '0;
        end else if (s2_en) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_result <= result_d;
                s2_tag    <= s1_tag;
            end
        end
    end

endmodule

// File: tb/tb_fp_add_pipe.sv
// Directed bench for fp_add_pipe (default parameters, 16-bit format).
module tb_fp_add_pipe;

    logic        clk_i;
    logic        rst_i;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [15:0] op_a_i;
    logic [15:0] op_b_i;
    logic        sub_i;
    logic [3:0]  tag_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [15:0] result_o;
    logic [3:0]  tag_o;

    int n_total = 0;
    int n_pass  = 0;

    fp_add_pipe dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .op_a_i      (op_a_i),
        .op_b_i      (op_b_i),
        .sub_i       (sub_i),
        .tag_i       (tag_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .result_o    (result_o),
        .tag_o       (tag_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    // One isolated operation with out_ready held high; checks latency, result, tag,
    // then drains the output so the pipeline is empty afterwards.
    task automatic run_op(input string name, input logic [15:0] a, input logic [15:0] b,
                          input logic s, input logic [3:0] t, input logic [15:0] exp_r);
        int  n;
        bit  got;
        op_a_i      = a;
        op_b_i      = b;
        sub_i       = s;
        tag_i       = t;
        in_valid_i  = 1'b1;
        out_ready_i = 1'b1;
        n   = 0;
        got = 1'b0;
        while (n < 10 && !got) begin
            @(posedge clk_i);
            #1;
            n++;
            in_valid_i = 1'b0;
            if (out_valid_o) got = 1'b1;
        end
        check({name, " latency"}, 32'(n), 32'd2);
        check({name, " result"}, 32'(result_o), 32'(exp_r));
        check({name, " tag"}, 32'(tag_o), 32'(t));
        @(posedge clk_i);
        #1;
        check({name, " drained"}, 32'(out_valid_o), 32'd0);
    endtask

    function automatic logic [15:0] stream_op(input int i);
        logic [7:0] e;
        logic [6:0] m;
        e = 8'h70 + 8'(i);
        m = 7'(i * 13);
        return {1'b0, e, m};
    endfunction

    // x + x doubles the value: exponent one higher, mantissa unchanged.
    function automatic logic [15:0] stream_exp(input int i);
        logic [7:0] e;
        logic [6:0] m;
        e = 8'h71 + 8'(i);
        m = 7'(i * 13);
        return {1'b0, e, m};
    endfunction

    initial begin
        int          sent;
        int          recv;
        int          inflight;
        int          cyc;
        bit          stalled;
        bit          acc_in;
        bit          acc_out;
        logic [15:0] held_r;
        logic [3:0]  held_t;

        rst_i       = 1'b1;
        in_valid_i  = 1'b0;
        op_a_i      = '0;
        op_b_i      = '0;
        sub_i       = 1'b0;
        tag_i       = '0;
        out_ready_i = 1'b1;
        repeat (3) @(posedge clk_i);
        #1;
        check("reset out_valid", 32'(out_valid_o), 32'd0);
        check("reset result", 32'(result_o), 32'd0);
        check("reset tag", 32'(tag_o), 32'd0);
        rst_i = 1'b0;
        check("reset in_ready", 32'(in_ready_o), 32'd1);

        // Directed arithmetic vectors
        run_op("1+1",        16'h3F80, 16'h3F80, 1'b0, 4'd5, 16'h4000);
        run_op("1-1",        16'h3F80, 16'h3F80, 1'b1, 4'd1, 16'h0000);
        run_op("3+-1",       16'h4040, 16'hBF80, 1'b0, 4'd2, 16'h4000);
        run_op("-1+0.5",     16'hBF80, 16'h3F00, 1'b0, 4'd3, 16'hBF00);
        run_op("gap20",      16'h3F80, 16'h3580, 1'b0, 4'd4, 16'h3F80);
        run_op("gap8",       16'h3F80, 16'h3B80, 1'b0, 4'd6, 16'h3F80);
        run_op("2-1",        16'h4000, 16'h3F80, 1'b1, 4'd7, 16'h3F80);
        run_op("sticky neg", 16'hBF80, 16'h3CC1, 1'b0, 4'd8, 16'hBF79);
`ifdef FP_ADD_PIPE_SAT_EN
        run_op("overflow",   16'h7FFF, 16'h7FFF, 1'b0, 4'd9, 16'h7FFF);
        run_op("underflow",  16'h0000, 16'h0040, 1'b1, 4'd10, 16'h0000);
`else
        run_op("overflow",   16'h7FFF, 16'h7FFF, 1'b0, 4'd9, 16'h007F);
        run_op("underflow",  16'h0000, 16'h0040, 1'b1, 4'd10, 16'hFF80);
`endif

        // Backpressure stream: out_ready follows 1,0,0,1 repeating.
        sent     = 0;
        recv     = 0;
        inflight = 0;
        cyc      = 0;
        stalled  = 1'b0;
        held_r   = '0;
        held_t   = '0;
        while (recv < 8 && cyc < 100) begin
            out_ready_i = (cyc % 4 == 0) || (cyc % 4 == 3);
            if (sent < 8) begin
                in_valid_i = 1'b1;
                op_a_i     = stream_op(sent);
                op_b_i     = stream_op(sent);
                sub_i      = 1'b0;
                tag_i      = 4'(sent);
            end else begin
                in_valid_i = 1'b0;
            end
            @(negedge clk_i);
            if (stalled) begin
                check("stall valid held", 32'(out_valid_o), 32'd1);
                check("stall result held", 32'(result_o), 32'(held_r));
                check("stall tag held", 32'(tag_o), 32'(held_t));
            end
            check("stream in_ready", 32'(in_ready_o),
                  32'(!(inflight == 2 && !out_ready_i)));
            acc_in  = in_valid_i && in_ready_o;
            acc_out = out_valid_o && out_ready_i;
            if (acc_out) begin
                check("stream result", 32'(result_o), 32'(stream_exp(recv)));
                check("stream tag", 32'(tag_o), 32'(recv));
                recv++;
            end
            stalled = out_valid_o && !out_ready_i;
            held_r  = result_o;
            held_t  = tag_o;
            if (acc_in) begin
                sent++;
                inflight++;
            end
            if (acc_out) inflight--;
            @(posedge clk_i);
            #1;
            cyc++;
        end
        check("stream count", 32'(recv), 32'd8);
        in_valid_i  = 1'b0;
        out_ready_i = 1'b1;
        repeat (3) @(posedge clk_i);
        #1;

        // Reset with both stages full and downstream stalled.
        out_ready_i = 1'b0;
        op_a_i      = 16'h3F80;
        op_b_i      = 16'h3F80;
        sub_i       = 1'b0;
        tag_i       = 4'd12;
        in_valid_i  = 1'b1;
        @(posedge clk_i);
        #1;
        tag_i = 4'd13;
        @(posedge clk_i);
        #1;
        in_valid_i = 1'b0;
        check("full out_valid", 32'(out_valid_o), 32'd1);
        check("full in_ready", 32'(in_ready_o), 32'd0);
        rst_i = 1'b1;
        @(posedge clk_i);
        #1;
        check("midreset out_valid", 32'(out_valid_o), 32'd0);
        check("midreset result", 32'(result_o), 32'd0);
        rst_i       = 1'b0;
        out_ready_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk_i);
            #1;
            check("no stale after reset", 32'(out_valid_o), 32'd0);
        end
        run_op("post reset", 16'h3F80, 16'h3F80, 1'b0, 4'd14, 16'h4000);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
